// File: rtl/i2s_capture_ctrl_pkg.sv
// Shared encodings for the I2S capture sequencer.
// State values are visible to software through the status register.
package i2s_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_WARMUP  = 3'd2,
    S_ARMED   = 3'd3,
    S_CAPTURE = 3'd4,
    S_FINISH  = 3'd5
  } state_e;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_VAD       = 1'b1;

endpackage

// File: rtl/i2s_stream_slice.sv
// One-entry valid/ready register between the RX FIFO head and the DMA stream.
// A load pops the FIFO in the same cycle, so data appears one cycle later.
module i2s_stream_slice #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          last_in,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          m_ready,
  output logic          fifo_rd,
  output logic          load,
  output logic          accept,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  assign accept  = m_valid & m_ready;
  assign load    = en & ~clr & ~fifo_empty
                 & (~m_valid | m_ready);
  assign fifo_rd = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (clr) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= fifo_rdata;
      m_last  <= last_in;
    end else if (accept) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// I2S receive sequencer: flush, warm-up discard, trigger wait,
// then deliver exactly len_q FIFO words on a valid/ready stream.
module i2s_capture_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int CW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          trig_sel,
  input  logic [7:0]    warmup_frames,
  input  logic [CW-1:0] capture_len,
  input  logic          ws,
  input  logic          vad_flag,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [DW-1:0] fifo_rdata,
  output logic          i2s_en,
  output logic          fifo_en,
  output logic          fifo_rd,
  output logic          fifo_flush,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [2:0]    state
);

  state_e        state_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] issued;
  logic [7:0]    frame_ctr;
  logic          ws_q;
  logic          overrun_q;
  logic          start_ok;
  logic          cap_en;
  logic          last_in;
  logic          load;
  logic          accept;
  logic          ws_rise;

  assign start_ok = (state_q == S_IDLE) & start & ~abort
                  & (capture_len != '0);
  assign cap_en   = (state_q == S_CAPTURE) & (issued != len_q);
  assign last_in  = (issued == len_q - CW'(1));
  assign ws_rise  = ws & ~ws_q;

  assign busy       = (state_q != S_IDLE);
  assign i2s_en     = busy;
  assign fifo_en    = (state_q == S_CAPTURE);
  assign fifo_flush = abort | (state_q == S_FLUSH);
  assign done       = (state_q == S_FINISH) & accept
                    & m_last & ~abort;
  assign overrun    = overrun_q;
  assign state      = state_q;

  i2s_stream_slice #(.DW(DW)) u_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (abort),
    .en         (cap_en),
    .last_in    (last_in),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .m_ready    (m_ready),
    .fifo_rd    (fifo_rd),
    .load       (load),
    .accept     (accept),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // Leave CAPTURE on the final load so its acceptance is seen in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      frame_ctr <= '0;
      ws_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      ws_q <= ws;
      if (state_q == S_CAPTURE && fifo_full)
        overrun_q <= 1'b1;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              state_q   <= S_FLUSH;
              len_q     <= capture_len;
              issued    <= '0;
              frame_ctr <= '0;
              overrun_q <= 1'b0;
            end
          end
          S_FLUSH: state_q <= S_WARMUP;
          S_WARMUP: begin
            if (frame_ctr == warmup_frames)
              state_q <= S_ARMED;
            else if (ws_rise)
              frame_ctr <= frame_ctr + 8'd1;
          end
          S_ARMED: begin
            if (trig_sel == TRIG_IMMEDIATE || vad_flag)
              state_q <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (load) begin
              issued <= issued + CW'(1);
              if (last_in)
                state_q <= S_FINISH;
            end
          end
          S_FINISH: begin
            if (accept && m_last)
              state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed + randomized bench for i2s_capture_ctrl with a FIFO/ws
// environment model and a word-level scoreboard.
module tb_i2s_capture_ctrl;

  localparam int CW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          trig_sel = 1'b0;
  logic [7:0]    warmup_frames = 8'd0;
  logic [CW-1:0] capture_len = '0;
  logic          ws = 1'b0;
  logic          vad_flag = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_full = 1'b0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_ready = 1'b0;
  logic          i2s_en, fifo_en, fifo_rd, fifo_flush;
  logic          m_valid, m_last, busy, done, overrun;
  logic [DW-1:0] m_data;
  logic [2:0]    state;

  i2s_capture_ctrl #(.CW(CW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .trig_sel(trig_sel), .warmup_frames(warmup_frames),
    .capture_len(capture_len), .ws(ws), .vad_flag(vad_flag),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rdata(fifo_rdata), .i2s_en(i2s_en), .fifo_en(fifo_en),
    .fifo_rd(fifo_rd), .fifo_flush(fifo_flush), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .overrun(overrun), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame clock and sink ready generators
  int   ws_half = 3;
  logic ws_run = 1'b0;
  int   ws_cnt = 0;
  int   rmode = 1;

  always @(negedge clk) begin
    if (ws_run) begin
      if (ws_cnt >= ws_half - 1) begin
        ws_cnt = 0;
        ws = ~ws;
      end else ws_cnt++;
    end
    case (rmode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      2: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Receiver + FIFO model: words enter only while fifo_en (or forced)
  logic [DW-1:0] src_mem [0:1023];
  int src_wr = 0, force_wr = 0, src_skip = 0, src_rd = 0;
  logic [DW-1:0] fq[$];
  int pops = 0, bad_rd = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (fifo_rd && (fifo_empty || state != 3'd4)) bad_rd++;
      if (fifo_flush) fq.delete();
      else if (fifo_rd) begin
        pops++;
        if (fq.size() > 0) void'(fq.pop_front());
      end
      if (src_rd < src_skip) src_rd = src_skip;
      if (src_rd < src_wr && (fifo_en || src_rd < force_wr)) begin
        fq.push_back(src_mem[src_rd]);
        src_rd++;
      end
      fifo_empty <= (fq.size() == 0);
      fifo_rdata <= (fq.size() != 0) ? fq[0] : '0;
    end
  end

  // Stream monitor
  logic [DW:0] got[$];
  int dones = 0, warm_rises = 0, armed_cyc = 0, stall_viol = 0;
  logic pv = 0, pr = 0, pl = 0, pab = 0, prise = 0, wsq = 1;
  logic [DW-1:0] pd = '0;
  logic [2:0] pst = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) got.push_back({m_last, m_data});
      if (done) dones++;
      if (state == 3'd3) armed_cyc++;
      if (pst == 3'd2 && prise && state == 3'd2) warm_rises++;
      if (pv && !pr && !pab &&
          (m_valid !== 1'b1 || m_data !== pd || m_last !== pl))
        stall_viol++;
      prise = ws & ~wsq;
      wsq = ws;
      pst = state;
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
      pab = abort;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int maxc,
                            input string tag);
    int i;
    i = 0;
    while (state !== tgt && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(state), 64'(tgt));
  endtask

  task automatic load_src(input int n, output int base);
    src_skip = src_wr;
    base = src_wr;
    for (int i = 0; i < n; i++) src_mem[src_wr + i] = $urandom;
    src_wr = src_wr + n;
  endtask

  task automatic do_start(input int len);
    capture_len = CW'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_stream(input int gbase, input int sbase,
                              input int len, input string tag);
    chk({tag, "_count"}, 64'(got.size() - gbase), 64'(len));
    for (int i = 0; i < len && gbase + i < got.size(); i++)
      chk(tag, 64'(got[gbase + i]),
          64'({(i == len - 1), src_mem[sbase + i]}));
  endtask

  initial begin
    int g0, d0, p0, wr0, a0, sb, hold_bad, len, warm, i;

    tick(3);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs",
        64'({i2s_en, fifo_en, fifo_rd, fifo_flush, m_valid,
             m_last, busy, done, overrun}), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    rst_n = 1'b1;
    ws_run = 1'b1;
    tick(2);

    // Immediate trigger with FIFO preloaded once armed
    rmode = 1; trig_sel = 1'b0; warmup_frames = 8'd2;
    g0 = got.size(); d0 = dones; p0 = pops;
    wr0 = warm_rises; a0 = armed_cyc;
    do_start(4);
    chk("t1_flush_st", 64'(state), 64'd1);
    chk("t1_flush", 64'(fifo_flush), 64'd1);
    tick(1);
    chk("t1_flush_off", 64'({fifo_flush, state}), 64'({1'b0, 3'd2}));
    wait_state(3'd3, 200, "t1_armed");
    src_skip = src_wr;
    sb = src_wr;
    for (int k = 0; k < 6; k++) src_mem[sb + k] = DW'(32'h11 * (k + 1));
    src_wr = sb + 6;
    force_wr = src_wr;
    wait_state(3'd0, 200, "t1_idle");
    tick(4);
    chk("t1_warm_rises", 64'(warm_rises - wr0), 64'd2);
    chk("t1_armed_cyc", 64'(armed_cyc - a0), 64'd1);
    check_stream(g0, sb, 4, "t1_word");
    chk("t1_done", 64'(dones - d0), 64'd1);
    chk("t1_pops", 64'(pops - p0), 64'd4);
    chk("t1_left_n", 64'(fq.size()), 64'd2);
    chk("t1_left0", 64'(fq.size() > 0 ? fq[0] : '1), 64'h55);
    chk("t1_left1", 64'(fq.size() > 1 ? fq[1] : '1), 64'h66);

    // Voice-activity trigger
    trig_sel = 1'b1; vad_flag = 1'b0; warmup_frames = 8'd1;
    load_src(8, sb);
    g0 = got.size(); d0 = dones;
    do_start(5);
    wait_state(3'd3, 200, "t2_armed");
    p0 = pops; hold_bad = 0;
    repeat (100) begin
      if (state !== 3'd3 || fifo_rd !== 1'b0) hold_bad++;
      tick(1);
    end
    chk("t2_hold", 64'(hold_bad), 64'd0);
    chk("t2_no_pop", 64'(pops - p0), 64'd0);
    vad_flag = 1'b1;
    tick(1);
    chk("t2_capture", 64'(state), 64'd4);
    vad_flag = 1'b0;
    wait_state(3'd0, 200, "t2_idle");
    check_stream(g0, sb, 5, "t2_word");
    chk("t2_done", 64'(dones - d0), 64'd1);

    // Backpressure
    trig_sel = 1'b0; warmup_frames = 8'd0; rmode = 2;
    load_src(6, sb);
    g0 = got.size(); d0 = dones; p0 = pops;
    do_start(3);
    wait_state(3'd0, 300, "t3_idle");
    check_stream(g0, sb, 3, "t3_word");
    chk("t3_pops", 64'(pops - p0), 64'd3);
    chk("t3_done", 64'(dones - d0), 64'd1);
    chk("t3_stall", 64'(stall_viol), 64'd0);

    // Abort after two words
    rmode = 1; warmup_frames = 8'd1;
    load_src(8, sb);
    g0 = got.size(); d0 = dones;
    do_start(8);
    i = 0;
    while (got.size() - g0 < 2 && i < 300) begin
      tick(1);
      i++;
    end
    chk("t4_two_words", 64'(got.size() - g0 >= 2), 64'd1);
    abort = 1'b1;
    #1;
    chk("t4_flush", 64'(fifo_flush), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("t4_idle", 64'({state, m_valid, m_last, i2s_en}), 64'd0);
    tick(3);
    chk("t4_no_done", 64'(dones - d0), 64'd0);

    // Edge cases
    do_start(0);
    chk("t5_len0", 64'({state, busy, fifo_flush}), 64'd0);
    capture_len = CW'(3);
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort", 64'({state, busy}), 64'd0);
    trig_sel = 1'b1; warmup_frames = 8'd0;
    load_src(10, sb);
    g0 = got.size(); d0 = dones;
    do_start(3);
    wait_state(3'd3, 200, "t5_armed");
    capture_len = CW'(7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t5_busy_start", 64'(state), 64'd3);
    tick(3);
    vad_flag = 1'b1;
    tick(1);
    vad_flag = 1'b0;
    wait_state(3'd0, 200, "t5_idle");
    check_stream(g0, sb, 3, "t5_word");
    chk("t5_done", 64'(dones - d0), 64'd1);

    // Overrun
    trig_sel = 1'b0; rmode = 0;
    load_src(6, sb);
    g0 = got.size(); d0 = dones;
    do_start(4);
    wait_state(3'd4, 200, "t6_capture");
    tick(2);
    chk("t6_pre", 64'(overrun), 64'd0);
    fifo_full = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    chk("t6_set", 64'(overrun), 64'd1);
    rmode = 1;
    wait_state(3'd0, 200, "t6_idle");
    chk("t6_done", 64'(dones - d0), 64'd1);
    chk("t6_hold", 64'(overrun), 64'd1);
    check_stream(g0, sb, 4, "t6_word");
    load_src(2, sb);
    do_start(1);
    chk("t6_clear", 64'(overrun), 64'd0);
    wait_state(3'd0, 200, "t6_idle2");

    // Randomized captures
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 8);
      warm = $urandom_range(0, 3);
      ws_half = $urandom_range(2, 4);
      rmode = $urandom_range(1, 3);
      warmup_frames = 8'(warm);
      load_src(len + $urandom_range(0, 4), sb);
      g0 = got.size(); d0 = dones; p0 = pops; wr0 = warm_rises;
      do_start(len);
      wait_state(3'd0, 2000, "rnd_idle");
      check_stream(g0, sb, len, "rnd_word");
      chk("rnd_done", 64'(dones - d0), 64'd1);
      chk("rnd_pops", 64'(pops - p0), 64'(len));
      chk("rnd_warm", 64'(warm_rises - wr0), 64'(warm));
    end

    chk("bad_fifo_rd", 64'(bad_rd), 64'd0);
    chk("stall_stable", 64'(stall_viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
